mem_bus_unit: RTL

Datapath-side responder for the multicycle CPU's memory control strobes: holds MAR and MDR, executes the read and write commands issued by the microcode controller against an external request/acknowledge memory port, and drives the shared internal bus with memory or MDR data. It turns single-cycle controller pulses (MARWr, MDRWr, MemRd, MemWr, MDROe, MemOe) into complete memory transactions. It reports `busy`/`done` so the controller can stall on variable memory latency.

---
 rtl/mem_bus_unit_pkg.sv | 16 +
 rtl/mem_bus_unit_timeout_cnt.sv | 29 ++
 rtl/mem_bus_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_bus_unit_pkg.sv
// Shared types and constants for the memory bus responder.
package mem_bus_unit_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic MDR_SRC_BUS = 1'b0;
    localparam logic MDR_SRC_MEM = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

endpackage

// File: rtl/mem_bus_unit_timeout_cnt.sv
// Request wait counter; tc is high on the last cycle allowed before abort.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Count holds edges already waited, so abort fires on edge TIMEOUT.
    assign tc = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_unit.sv
// MAR/MDR holder that turns controller strobes into req/ack memory transactions.
module mem_bus_unit
    import mem_bus_unit_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              MARWr,
    input  logic              MDRWr,
    input  logic              MDRSrc,
    input  logic              MemRd,
    input  logic              MemWr,
    input  logic              MDROe,
    input  logic              MemOe,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_out_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t state, state_nxt;

    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] rdb;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              ld_mdr;

    logic is_idle, is_req, is_done;
    logic cmd_any, misalign, issue;
    logic ack_ok, abort, tc, err_set;

    assign is_idle  = (state == IDLE);
    assign is_req   = (state == REQ);
    assign is_done  = (state == DONE);
    assign cmd_any  = MemRd | MemWr;
    assign misalign = |mar[1:0];
    assign issue    = is_idle & (MemRd ^ MemWr) & !misalign;
    assign ack_ok   = is_req & mem_ack;
    assign abort    = is_req & !mem_ack & tc;

    // Any rejected command, REQ-time register write, timeout or bus clash.
    assign err_set = (is_idle & cmd_any & !issue)
                   | (!is_idle & cmd_any)
                   | (is_req & MARWr)
                   | (is_req & MDRWr & (MDRSrc == MDR_SRC_BUS))
                   | abort
                   | (MDROe & MemOe);

    mem_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (issue),
        .inc  (is_req),
        .tc   (tc)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (issue) state_nxt = REQ;
            REQ:     if (mem_ack || tc) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar     <= '0;
            mdr     <= '0;
            rdb     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            ld_mdr  <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (MARWr && !is_req) begin
                mar <= bus_in;
            end
            if (ack_ok && !we_q) begin
                rdb <= mem_rdata;
            end
            if (ack_ok && !we_q && ld_mdr) begin
                mdr <= mem_rdata;
            end else if (MDRWr && MDRSrc == MDR_SRC_BUS && !is_req) begin
                mdr <= bus_in;
            end
            if (issue) begin
                we_q    <= MemWr;
                addr_q  <= mar;
                wdata_q <= mdr;
                ld_mdr  <= MemRd & (MDRSrc == MDR_SRC_MEM) & MDRWr;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    assign busy      = is_req;
    assign done      = is_done;
    assign mem_req   = is_req;
    assign mem_we    = is_req & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // MDR has priority when both output enables collide.
    always_comb begin
        bus_out    = '0;
        bus_out_en = MDROe | MemOe;
        if (MDROe) begin
            bus_out = mdr;
        end else if (MemOe) begin
            bus_out = rdb;
        end
    end

endmodule
